// File: rtl/serial_adder_pkg.sv
// Shared types for the bit-serial adder.
// FSM state encoding and width limits.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 32;

endpackage

// File: rtl/serial_adder_ctrl_fa_bit.sv
// One-bit full adder: two half adders plus an OR.
// Ports: x, y, ci in; s, co out.
module fa_bit (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  logic h1_s;
  logic h1_c;
  logic h2_c;

  assign h1_s = x ^ y;
  assign h1_c = x & y;
  assign s    = h1_s ^ ci;
  assign h2_c = h1_s & ci;
  assign co   = h1_c | h2_c;

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller, LSB first, one bit/clk.
// Ports: clk, rst, start, a, b, cin -> busy, done, sum, cout.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(WIDTH - 1);

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic [WIDTH-1:0] sum_d;
  logic [CNT_W-1:0] cnt_q;
  logic             carry_q;
  logic             cout_q;
  logic             busy_q;
  logic             done_q;
  logic             fa_s;
  logic             fa_co;

  fa_bit u_fa (
    .x  (a_q[0]),
    .y  (b_q[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  assign sum_d = {fa_s, sum_q[WIDTH-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= cin;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          sum_q   <= sum_d;
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          carry_q <= fa_co;
          if (cnt_q == CNT_MAX) begin
            // park at 0 so it never passes WIDTH-1
            cnt_q   <= '0;
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            cout_q  <= fa_co;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl.
// Random and exhaustive adds vs a + b + cin.
module tb_serial_adder_ctrl;

  localparam int W = 4;

  typedef struct {
    logic [W:0] exp;
    int         acc;
  } sb_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  sb_t        sb[$];
  int         n_cmp = 0;
  int         n_err = 0;
  int         n_done = 0;
  int         cyc = 0;
  int         busy_run = 0;
  logic [W:0] last = '0;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check(input string nm,
                       input longint act,
                       input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d",
               nm, act, exp);
    end
  endtask

  task automatic check_fail(input string nm);
    n_cmp++;
    n_err++;
    $display("FAIL %s: got event want none", nm);
  endtask

  // monitor: pops the scoreboard on each done pulse
  always @(negedge clk) begin
    if (!rst) begin
      if (busy) busy_run++;
      if (done) begin
        n_done++;
        if (sb.size() == 0) begin
          check_fail("spurious_done");
        end else begin
          sb_t e;
          e = sb.pop_front();
          check("result", {cout, sum}, e.exp);
          check("latency", cyc - e.acc, W);
          check("busy_cycles", busy_run, W);
        end
        last = {cout, sum};
        busy_run = 0;
      end else if (!busy) begin
        check("hold", {cout, sum}, last);
      end
    end
  end

  task automatic issue(input logic [W-1:0] ia,
                       input logic [W-1:0] ib,
                       input logic ic);
    int g;
    g = 0;
    @(negedge clk);
    while ((busy || done) && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (g >= 50) check_fail("idle_timeout");
    a = ia;
    b = ib;
    cin = ic;
    start = 1'b1;
    sb.push_back('{exp: {1'b0, ia} + {1'b0, ib}
                        + (W+1)'(ic),
                   acc: cyc + 1});
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    cin = 1'($urandom);
  endtask

  task automatic do_reset();
    @(negedge clk);
    a = W'($urandom);
    b = W'($urandom);
    cin = 1'($urandom);
    #2 rst = 1'b1;
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    sb.delete();
    busy_run = 0;
    last = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (sb.size() > 0 && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (sb.size() > 0) check_fail("drain_timeout");
  endtask

  initial begin
    int d0;
    int g;
    #1;
    check("init_busy", busy, 0);
    check("init_done", done, 0);
    check("init_sum", {cout, sum}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    issue(4'd5, 4'd3, 1'b0);
    issue(4'd15, 4'd1, 1'b0);
    issue(4'd15, 4'd15, 1'b1);

    // start held with zeroed operands through RUN/DONE
    issue(4'd5, 4'd3, 1'b0);
    g = 0;
    while (g < 20) begin
      @(negedge clk);
      g++;
      if (!busy && !done) begin
        a = 4'd7;
        b = 4'd6;
        cin = 1'b1;
        sb.push_back('{exp: 5'd14, acc: cyc + 1});
        @(negedge clk);
        start = 1'b0;
        break;
      end
      start = 1'b1;
      a = '0;
      b = '0;
    end
    if (g >= 20) check_fail("held_start_timeout");
    drain();

    issue(4'd9, 4'd7, 1'b0);
    @(negedge clk);
    do_reset();
    issue(4'd2, 4'd2, 1'b0);
    drain();

    for (int i = 0; i < 150; i++) begin
      issue(W'($urandom), W'($urandom),
            1'($urandom));
      if ($urandom_range(0, 19) == 0) begin
        repeat ($urandom_range(0, 1))
          @(negedge clk);
        do_reset();
      end
    end
    drain();

    d0 = n_done;
    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++)
        for (int c = 0; c < 2; c++)
          issue(W'(x), W'(y), 1'(c));
    drain();
    check("sweep_done_count", n_done - d0, 512);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
